// File: rtl/core_pkg.sv
// Shared core definitions: default fetch widths, the fetch entry layout and
// the sequential-fetch PC increment.
package core_pkg;

  localparam int unsigned PC_SIZE_DEF   = 18;
  localparam int unsigned MEM_SIZE_DEF  = 16;
  localparam int unsigned DATA_SIZE_DEF = 32;

  // Byte distance between consecutive instructions.
  localparam int unsigned PC_INCR = 4;

  // One buffered instruction together with the byte PC it was fetched from.
  typedef struct packed {
    logic [PC_SIZE_DEF-1:0]   pc;
    logic [DATA_SIZE_DEF-1:0] inst;
  } fetch_entry_t;

  // Bits needed to hold an occupancy count of 0..depth.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// Bus bundle of the fetch front end: instruction-memory read port, redirect
// input and the decode-side valid/ready handshake.
interface fetch_prefetch_unit_if
  import core_pkg::*;
#(
  parameter int unsigned PC_SIZE   = PC_SIZE_DEF,
  parameter int unsigned MEM_SIZE  = MEM_SIZE_DEF,
  parameter int unsigned DATA_SIZE = DATA_SIZE_DEF
);

  logic [MEM_SIZE-1:0]  IM_Address;
  logic                 IM_req;
  logic [DATA_SIZE-1:0] Instruction;
  logic                 redirect_valid;
  logic [PC_SIZE-1:0]   redirect_pc;
  logic                 inst_valid;
  logic [DATA_SIZE-1:0] inst;
  logic [PC_SIZE-1:0]   inst_pc;
  logic                 inst_ready;

  // Fetch unit side.
  modport master (
    output IM_Address, IM_req, inst_valid, inst, inst_pc,
    input  Instruction, redirect_valid, redirect_pc, inst_ready
  );

  // Memory / decode / branch-unit side.
  modport slave (
    input  IM_Address, IM_req, inst_valid, inst, inst_pc,
    output Instruction, redirect_valid, redirect_pc, inst_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO. A pop is applied before a flush, and a flush
// wins over a push, so a redirect clears everything including the word that
// is returning in the same cycle. The head is forced to zero when empty.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         entry_t = fetch_entry_t,
  localparam int unsigned CNT_W = cnt_width(DEPTH),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  entry_t           push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] count_o,
  output entry_t           head_o
);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;
  logic             do_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && !flush_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  // Next-state for pointers and occupancy.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until written because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign count_o = count_q;
  assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Credit-based instruction prefetcher. Issues one IM read per cycle while a
// FIFO slot is guaranteed for the returning word, tags each return with its
// PC and presents the oldest entry to decode. A redirect drops all buffered
// and in-flight work and restarts fetch at the (word-aligned) target.
// MEM_SIZE must equal PC_SIZE-2 and DEPTH must be at least 1.
module fetch_prefetch_unit
  import core_pkg::*;
#(
  parameter int unsigned PC_SIZE   = PC_SIZE_DEF,
  parameter int unsigned MEM_SIZE  = MEM_SIZE_DEF,
  parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
  parameter int unsigned DEPTH     = 4
) (
  input logic                  clk,
  input logic                  rst,
  fetch_prefetch_unit_if.master bus
);

  localparam int unsigned CNT_W = cnt_width(DEPTH);

  typedef struct packed {
    logic [PC_SIZE-1:0]   pc;
    logic [DATA_SIZE-1:0] inst;
  } entry_t;

  logic [PC_SIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic               running_q;
  logic               inflight_q, inflight_d;
  logic [PC_SIZE-1:0] inflight_pc_q, inflight_pc_d;

  logic [CNT_W-1:0]   count;
  entry_t             head;
  entry_t             push_data;
  logic               issue;
  logic               push;
  logic               pop;
  logic               flush;
  logic [CNT_W:0]     credit_used;
  logic               unused_redirect_lsbs;

  assign pop   = bus.inst_valid && bus.inst_ready;
  assign flush = bus.redirect_valid;
  assign push  = inflight_q && !bus.redirect_valid;

  // Credits in use after this cycle's pop. Counting the departing head lets a
  // full FIFO refill without a bubble (one instruction every 2 cycles at
  // DEPTH=1, one per cycle at DEPTH>=2) while still guaranteeing that the word
  // returning next cycle has a slot.
  assign credit_used = {1'b0, count}
                     + {{CNT_W{1'b0}}, inflight_q}
                     - {{CNT_W{1'b0}}, pop};

  assign issue = running_q && !bus.redirect_valid && (credit_used < (CNT_W + 1)'(DEPTH));

  assign push_data = '{pc: inflight_pc_q, inst: bus.Instruction};

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .flush_i     (flush),
    .count_o     (count),
    .head_o      (head)
  );

  assign bus.IM_req     = issue;
  assign bus.IM_Address = fetch_pc_q[PC_SIZE-1:2];
  assign bus.inst_valid = (count != '0);
  assign bus.inst       = head.inst;
  assign bus.inst_pc    = head.pc;

  // The redirect target is always treated as word aligned.
  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

  // Next fetch PC and in-flight tracking: redirect overrides sequential advance.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    if (flush) begin
      fetch_pc_d = {bus.redirect_pc[PC_SIZE-1:2], 2'b00};
      inflight_d = 1'b0;
    end else if (issue) begin
      fetch_pc_d    = fetch_pc_q + PC_SIZE'(PC_INCR);
      inflight_pc_d = fetch_pc_q;
    end
  end

  // Fetch state registers; running arms on the first edge out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= '0;
      running_q     <= 1'b0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      running_q     <= 1'b1;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: a DEPTH=4 instance for the main
// scenarios and a DEPTH=1 instance for the low-depth throughput case.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_fetch_prefetch_unit;

  logic clk = 1'b0;
  logic rst4;
  logic rst1;
  int   checks = 0;
  int   errors = 0;
  logic [17:0] exp_pc4;

  always #5 clk = ~clk;

  fetch_prefetch_unit_if #(.PC_SIZE(18), .MEM_SIZE(16), .DATA_SIZE(32)) bus4 ();
  fetch_prefetch_unit_if #(.PC_SIZE(18), .MEM_SIZE(16), .DATA_SIZE(32)) bus1 ();

  fetch_prefetch_unit #(.PC_SIZE(18), .MEM_SIZE(16), .DATA_SIZE(32), .DEPTH(4)) dut4 (
    .clk (clk), .rst (rst4), .bus (bus4.master)
  );
  fetch_prefetch_unit #(.PC_SIZE(18), .MEM_SIZE(16), .DATA_SIZE(32), .DEPTH(1)) dut1 (
    .clk (clk), .rst (rst1), .bus (bus1.master)
  );

  // Instruction memories: 1-cycle latency, word = {C0DE, word address}.
  always @(posedge clk) if (bus4.IM_req) bus4.Instruction <= {16'hC0DE, bus4.IM_Address};
  always @(posedge clk) if (bus1.IM_req) bus1.Instruction <= {16'hC0DE, bus1.IM_Address};

  task automatic test_reset();
    @(negedge clk); #1;
    checks++;
    if ({bus4.IM_req, bus4.IM_Address, bus4.inst_valid} !== 18'h0) begin
      errors++; $display("FAIL reset_ctrl4: got req=%b addr=%h valid=%b want 0", bus4.IM_req, bus4.IM_Address, bus4.inst_valid);
    end
    checks++;
    if ({bus4.inst, bus4.inst_pc} !== 50'h0) begin
      errors++; $display("FAIL reset_head4: got inst=%h pc=%h want 0", bus4.inst, bus4.inst_pc);
    end
    checks++;
    if ({bus1.IM_req, bus1.inst_valid, bus1.inst_pc} !== 20'h0) begin
      errors++; $display("FAIL reset_dut1: got req=%b valid=%b pc=%h want 0", bus1.IM_req, bus1.inst_valid, bus1.inst_pc);
    end
  endtask

  task automatic test_startup();
    rst4 = 1'b1;
    bus4.inst_ready = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk); #1;
      if (c == 1) begin
        checks++;
        if ({bus4.IM_req, bus4.IM_Address} !== 17'h1_0000) begin
          errors++; $display("FAIL startup_first_req: got req=%b addr=%h want 1/0000", bus4.IM_req, bus4.IM_Address);
        end
      end
      if (c < 3) begin
        checks++;
        if (bus4.inst_valid !== 1'b0) begin
          errors++; $display("FAIL startup_early_valid c%0d: got %b want 0", c, bus4.inst_valid);
        end
      end else begin
        checks++;
        if ({bus4.inst_valid, bus4.inst_pc, bus4.inst} !== {1'b1, 18'((c - 3) * 4), 16'hC0DE, 16'(c - 3)}) begin
          errors++; $display("FAIL startup_stream c%0d: got v=%b pc=%h inst=%h want pc=%h", c, bus4.inst_valid, bus4.inst_pc, bus4.inst, 18'((c - 3) * 4));
        end
      end
    end
    exp_pc4 = 18'h28;
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus4.inst_ready = 1'b0;
      #1;
      checks++;
      if (bus4.IM_req !== (k < 2)) begin
        errors++; $display("FAIL bp_req k%0d: got %b want %b", k, bus4.IM_req, (k < 2));
      end
      checks++;
      if ({bus4.inst_valid, bus4.inst_pc} !== {1'b1, exp_pc4}) begin
        errors++; $display("FAIL bp_hold k%0d: got v=%b pc=%h want pc=%h", k, bus4.inst_valid, bus4.inst_pc, exp_pc4);
      end
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      bus4.inst_ready = 1'b1;
      #1;
      if (k == 0) begin
        checks++;
        if (bus4.IM_req !== 1'b1) begin
          errors++; $display("FAIL bp_refill_req: got %b want 1", bus4.IM_req);
        end
      end
      checks++;
      if ({bus4.inst_valid, bus4.inst_pc, bus4.inst} !== {1'b1, exp_pc4, 16'hC0DE, exp_pc4[17:2]}) begin
        errors++; $display("FAIL bp_resume k%0d: got v=%b pc=%h inst=%h want pc=%h", k, bus4.inst_valid, bus4.inst_pc, bus4.inst, exp_pc4);
      end
      exp_pc4 = exp_pc4 + 18'd4;
    end
  endtask

  task automatic test_redirect_full();
    @(negedge clk);
    bus4.inst_ready = 1'b0;
    bus4.redirect_valid = 1'b1;
    bus4.redirect_pc = 18'h10;
    #1;
    checks++;
    if (bus4.IM_req !== 1'b0) begin
      errors++; $display("FAIL rf_setup_req: got %b want 0", bus4.IM_req);
    end
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      bus4.redirect_valid = 1'b0;
      #1;
      if (k == 1) begin
        checks++;
        if ({bus4.IM_req, bus4.IM_Address, bus4.inst_valid} !== {1'b1, 16'h0004, 1'b0}) begin
          errors++; $display("FAIL rf_refetch: got req=%b addr=%h v=%b want 1/0004/0", bus4.IM_req, bus4.IM_Address, bus4.inst_valid);
        end
      end
      if (k >= 6) begin
        checks++;
        if ({bus4.IM_req, bus4.inst_valid, bus4.inst_pc} !== {1'b0, 1'b1, 18'h10}) begin
          errors++; $display("FAIL rf_full k%0d: got req=%b v=%b pc=%h want 0/1/00010", k, bus4.IM_req, bus4.inst_valid, bus4.inst_pc);
        end
      end
    end
    // Redirect together with a pop of 0x10.
    @(negedge clk);
    bus4.inst_ready = 1'b1;
    bus4.redirect_valid = 1'b1;
    bus4.redirect_pc = 18'h200;
    #1;
    checks++;
    if ({bus4.IM_req, bus4.inst_valid, bus4.inst_pc} !== {1'b0, 1'b1, 18'h10}) begin
      errors++; $display("FAIL rf_pop_redirect: got req=%b v=%b pc=%h want 0/1/00010", bus4.IM_req, bus4.inst_valid, bus4.inst_pc);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus4.redirect_valid = 1'b0;
      #1;
      if (k == 1) begin
        checks++;
        if ({bus4.IM_req, bus4.IM_Address} !== {1'b1, 16'h0080}) begin
          errors++; $display("FAIL rf_target_req: got req=%b addr=%h want 1/0080", bus4.IM_req, bus4.IM_Address);
        end
      end
      if (k < 3) begin
        checks++;
        if (bus4.inst_valid !== 1'b0) begin
          errors++; $display("FAIL rf_flushed k%0d: got v=%b pc=%h want empty", k, bus4.inst_valid, bus4.inst_pc);
        end
      end else begin
        checks++;
        if ({bus4.inst_valid, bus4.inst_pc} !== {1'b1, 18'(18'h200 + (k - 3) * 4)}) begin
          errors++; $display("FAIL rf_target k%0d: got v=%b pc=%h want %h", k, bus4.inst_valid, bus4.inst_pc, 18'(18'h200 + (k - 3) * 4));
        end
      end
    end
  endtask

  task automatic test_misaligned_back_to_back();
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      bus4.redirect_valid = (k < 2);
      bus4.redirect_pc = (k == 0) ? 18'h103 : 18'h400;
      #1;
      checks++;
      if (bus4.IM_req === 1'b1 && bus4.IM_Address === 16'h0040) begin
        errors++; $display("FAIL b2b_stale_fetch k%0d: got addr=%h want never 0040", k, bus4.IM_Address);
      end
      case (k)
        0: begin
          checks++;
          if (bus4.IM_req !== 1'b0) begin
            errors++; $display("FAIL b2b_req_r: got %b want 0", bus4.IM_req);
          end
        end
        1: begin
          checks++;
          if ({bus4.IM_req, bus4.inst_valid} !== 2'b00) begin
            errors++; $display("FAIL b2b_r1: got req=%b v=%b want 0/0", bus4.IM_req, bus4.inst_valid);
          end
        end
        2: begin
          checks++;
          if ({bus4.IM_req, bus4.IM_Address, bus4.inst_valid} !== {1'b1, 16'h0100, 1'b0}) begin
            errors++; $display("FAIL b2b_first_addr: got req=%b addr=%h v=%b want 1/0100/0", bus4.IM_req, bus4.IM_Address, bus4.inst_valid);
          end
        end
        3: begin
          checks++;
          if ({bus4.IM_Address, bus4.inst_valid} !== {16'h0101, 1'b0}) begin
            errors++; $display("FAIL b2b_r3: got addr=%h v=%b want 0101/0", bus4.IM_Address, bus4.inst_valid);
          end
        end
        default: begin
          checks++;
          if ({bus4.inst_valid, bus4.inst_pc, bus4.inst} !== {1'b1, 18'(18'h400 + (k - 4) * 4), 16'hC0DE, 16'(16'h0100 + k - 4)}) begin
            errors++; $display("FAIL b2b_target k%0d: got v=%b pc=%h inst=%h want pc=%h", k, bus4.inst_valid, bus4.inst_pc, bus4.inst, 18'(18'h400 + (k - 4) * 4));
          end
        end
      endcase
    end
  endtask

  task automatic test_wrap();
    logic [17:0] exp_pcs [3];
    exp_pcs[0] = 18'h3FFF8;
    exp_pcs[1] = 18'h3FFFC;
    exp_pcs[2] = 18'h00000;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      bus4.redirect_valid = (k == 0);
      bus4.redirect_pc = 18'h3FFF8;
      #1;
      if (k >= 1 && k <= 3) begin
        checks++;
        if ({bus4.IM_req, bus4.IM_Address} !== {1'b1, 16'(16'hFFFE + k - 1)}) begin
          errors++; $display("FAIL wrap_addr k%0d: got req=%b addr=%h want %h", k, bus4.IM_req, bus4.IM_Address, 16'(16'hFFFE + k - 1));
        end
      end
      if (k >= 3) begin
        checks++;
        if ({bus4.inst_valid, bus4.inst_pc, bus4.inst} !== {1'b1, exp_pcs[k - 3], 16'hC0DE, exp_pcs[k - 3][17:2]}) begin
          errors++; $display("FAIL wrap_seq k%0d: got v=%b pc=%h inst=%h want pc=%h", k, bus4.inst_valid, bus4.inst_pc, bus4.inst, exp_pcs[k - 3]);
        end
      end
    end
  endtask

  task automatic test_midstream_reset();
    @(negedge clk); #3;
    rst4 = 1'b0;
    #1;
    checks++;
    if ({bus4.IM_req, bus4.IM_Address, bus4.inst_valid, bus4.inst, bus4.inst_pc} !== 68'h0) begin
      errors++; $display("FAIL async_reset: got req=%b addr=%h v=%b inst=%h pc=%h want 0", bus4.IM_req, bus4.IM_Address, bus4.inst_valid, bus4.inst, bus4.inst_pc);
    end
    @(negedge clk);
    rst4 = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); #1;
      if (c == 1) begin
        checks++;
        if ({bus4.IM_req, bus4.IM_Address, bus4.inst_valid} !== {1'b1, 16'h0, 1'b0}) begin
          errors++; $display("FAIL restart_req: got req=%b addr=%h v=%b want 1/0000/0", bus4.IM_req, bus4.IM_Address, bus4.inst_valid);
        end
      end
      if (c >= 3) begin
        checks++;
        if ({bus4.inst_valid, bus4.inst_pc} !== {1'b1, 18'((c - 3) * 4)}) begin
          errors++; $display("FAIL restart_pc c%0d: got v=%b pc=%h want %h", c, bus4.inst_valid, bus4.inst_pc, 18'((c - 3) * 4));
        end
      end
    end
  endtask

  task automatic test_depth1();
    @(negedge clk);
    rst1 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk); #1;
      checks++;
      if (bus1.IM_req !== c[0]) begin
        errors++; $display("FAIL d1_req c%0d: got %b want %b", c, bus1.IM_req, c[0]);
      end
      checks++;
      if (bus1.inst_valid !== (c >= 3 && c[0])) begin
        errors++; $display("FAIL d1_valid c%0d: got %b want %b", c, bus1.inst_valid, (c >= 3 && c[0]));
      end
      if (c >= 3 && c[0]) begin
        checks++;
        if (bus1.inst_pc !== 18'(((c - 3) / 2) * 4)) begin
          errors++; $display("FAIL d1_pc c%0d: got %h want %h", c, bus1.inst_pc, 18'(((c - 3) / 2) * 4));
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst4 = 1'b0;
    rst1 = 1'b0;
    bus4.redirect_valid = 1'b0;
    bus4.redirect_pc = '0;
    bus4.inst_ready = 1'b0;
    bus1.redirect_valid = 1'b0;
    bus1.redirect_pc = '0;
    bus1.inst_ready = 1'b1;
    exp_pc4 = '0;
    test_reset();
    test_startup();
    test_backpressure();
    test_redirect_full();
    test_misaligned_back_to_back();
    test_wrap();
    test_midstream_reset();
    test_depth1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
